// File: rtl/spi_master_shifter.sv
// SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first.
// An upstream divider supplies `tick`, one pulse per SCLK half-period.
// A transfer runs IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. Acceptance to the
// done pulse takes exactly 2*DATA_W+2 ticks. Every output comes from a register.
module spi_master_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] tx_sh_r;
  logic [DATA_W-1:0] rx_sh_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] tx_next_s;
  logic [DATA_W-1:0] rx_next_s;

  // Next values of both shift registers. Written this way so DATA_W=1 also elaborates.
  always_comb begin
    tx_next_s    = tx_sh_r << 1'b1;
    rx_next_s    = rx_sh_r << 1'b1;
    rx_next_s[0] = miso;
  end

  // Transfer FSM. It drives all outputs as registers, and nothing advances without a tick once busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= {DATA_W{1'b0}};
      tx_sh_r   <= {DATA_W{1'b0}};
      rx_sh_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= CNT_ZERO;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // A tick arriving with start does not count. SETUP always waits for a later tick.
          if (start) begin
            tx_sh_r   <= tx_data;
            rx_sh_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= CNT_ZERO;
            mosi      <= tx_data[DATA_W-1];
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            state_r   <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          // The first tick gives one half-period of CS setup. SCLK stays low.
          if (tick) begin
            state_r <= SHIFT;
          end else begin
            state_r <= SETUP;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              // Rising edge: sample the slave.
              sclk      <= 1'b1;
              rx_sh_r   <= rx_next_s;
              bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end else begin
              // Falling edge: present the next bit, or finish after the last bit.
              sclk <= 1'b0;
              if (bit_cnt_r == CNT_LAST) begin
                mosi    <= 1'b0;
                state_r <= HOLD;
              end else begin
                tx_sh_r <= tx_next_s;
                mosi    <= tx_next_s[DATA_W-1];
              end
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        HOLD: begin
          // The final tick releases CS and publishes the received word.
          if (tick) begin
            cs_n    <= 1'b1;
            rx_data <= rx_sh_r;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
          sclk    <= 1'b0;
          mosi    <= 1'b0;
          cs_n    <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
